data_memory_ctrl: RTL and testbench

Parametrised, byte-addressable, little-endian data memory for the CPU's MEM stage. Supports byte, halfword and word loads and stores, with sign or zero extension on loads. Uses a request/ready handshake with a configurable access latency and flags misaligned, illegal-size and out-of-range accesses. Intended to replace the fixed 32-byte, word-only data memory and allow slower memory models to be simulated.

---
 rtl/data_memory_ctrl_if.sv | 28 ++
 rtl/data_memory_ctrl.sv | 176 +++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_ctrl_if.sv
// data_memory_ctrl_if: request/response bus of the MEM-stage data memory.
//   req_i/we_i/size_i/sign_i/addr_i/data_i : request from the CPU (master)
//   ready_o                                : memory can accept a request this cycle
//   rvalid_o/data_o/err_o                  : one-cycle response strobe, load data, error flag
interface data_memory_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_i;
  logic              we_i;
  logic [1:0]        size_i;
  logic              sign_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       data_i;
  logic              ready_o;
  logic              rvalid_o;
  logic [31:0]       data_o;
  logic              err_o;

  modport slave (
    input  req_i, we_i, size_i, sign_i, addr_i, data_i,
    output ready_o, rvalid_o, data_o, err_o
  );

  modport master (
    output req_i, we_i, size_i, sign_i, addr_i, data_i,
    input  ready_o, rvalid_o, data_o, err_o
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressable little-endian data memory with byte/half/word
// loads and stores, sign/zero extension, a request/ready handshake and a
// configurable access latency. Misaligned, illegal-size and out-of-range accesses
// complete normally but return err_o = 1 and data_o = 0 without touching memory.
// Ports:
//   clk_i : clock, all state updates on the rising edge
//   rst_i : synchronous active-high reset (control only, memory is preserved)
//   bus   : data_memory_ctrl_if slave modport (request, ready, response)
module data_memory_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  data_memory_ctrl_if.slave   bus
);

  localparam int IDX_W    = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam int CNT_W    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam int CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // End address is computed one bit wider so an access near the top of the
  // address space cannot wrap around and look in range.
  function automatic logic access_err(input logic [1:0] size, input logic [ADDR_W-1:0] addr);
    logic [ADDR_W:0] end_addr;
    logic            misaligned;
    end_addr   = {1'b0, addr} + (ADDR_W + 1)'(size_bytes(size));
    misaligned = ((size == 2'b01) && addr[0]) || ((size == 2'b10) && (addr[1:0] != 2'b00));
    return (size == 2'b11) || misaligned || (end_addr > DEPTH_L);
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic sign,
                                              input logic [31:0] raw);
    case (size)
      2'b00:   return {{24{sign & raw[7]}}, raw[7:0]};
      2'b01:   return {{16{sign & raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  state_t            state;
  logic [CNT_W-1:0]  cnt;

  logic              we_p0;
  logic              sign_p0;
  logic [1:0]        size_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [31:0]       wdata_p0;

  logic              accept;
  logic              commit;
  logic              op_we;
  logic              op_sign;
  logic              op_err;
  logic [1:0]        op_size;
  logic [ADDR_W-1:0] op_addr;
  logic [31:0]       op_wdata;
  logic [IDX_W-1:0]  base;
  logic [31:0]       rd_raw;

  logic [7:0]        mem [DEPTH_BYTES];

  assign accept = bus.req_i && bus.ready_o;

  // With single-cycle latency the commit edge is the accept edge, so the
  // operation comes straight from the bus; otherwise from the latched request.
  assign op_we    = (LATENCY == 1) ? bus.we_i   : we_p0;
  assign op_sign  = (LATENCY == 1) ? bus.sign_i : sign_p0;
  assign op_size  = (LATENCY == 1) ? bus.size_i : size_p0;
  assign op_addr  = (LATENCY == 1) ? bus.addr_i : addr_p0;
  assign op_wdata = (LATENCY == 1) ? bus.data_i : wdata_p0;
  assign op_err   = access_err(op_size, op_addr);
  assign base     = op_addr[IDX_W-1:0];

  // Reset suppresses the commit, which both drops an outstanding request and
  // lets reset win over a simultaneous accept.
  assign commit = !rst_i && ((LATENCY == 1) ? accept : ((state == S_WAIT) && (cnt == '0)));

  // Aligned accesses never cross a word, so base + k stays inside the word.
  always_comb begin
    rd_raw       = '0;
    rd_raw[7:0]  = mem[base];
    if (op_size != 2'b00) begin
      rd_raw[15:8] = mem[base + IDX_W'(1)];
    end
    if (op_size == 2'b10) begin
      rd_raw[23:16] = mem[base + IDX_W'(2)];
      rd_raw[31:24] = mem[base + IDX_W'(3)];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bus.ready_o  <= 1'b1;
      bus.rvalid_o <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          if (cnt == '0) begin
            state        <= S_RESP;
            bus.ready_o  <= 1'b1;
            bus.rvalid_o <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          if (accept && (LATENCY == 1)) begin
            state        <= S_RESP;
            bus.ready_o  <= 1'b1;
            bus.rvalid_o <= 1'b1;
          end else if (accept) begin
            state        <= S_WAIT;
            cnt          <= CNT_W'(CNT_INIT);
            bus.ready_o  <= 1'b0;
            bus.rvalid_o <= 1'b0;
          end else begin
            state        <= S_IDLE;
            bus.ready_o  <= 1'b1;
            bus.rvalid_o <= 1'b0;
          end
        end
      endcase
    end
  end

  // Stage p0: request latched at acceptance
  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_p0    <= bus.we_i;
      sign_p0  <= bus.sign_i;
      size_p0  <= bus.size_i;
      addr_p0  <= bus.addr_i;
      wdata_p0 <= bus.data_i;
    end
  end

  // Stage p1: commit edge, response data and error are registered here
  always_ff @(posedge clk_i) begin
    if (commit) begin
      bus.err_o  <= op_err;
      bus.data_o <= (op_err || op_we) ? 32'd0 : load_extend(op_size, op_sign, rd_raw);
    end else begin
      bus.err_o  <= 1'b0;
      bus.data_o <= 32'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (commit && op_we && !op_err) begin
      mem[base] <= op_wdata[7:0];
      if (op_size != 2'b00) begin
        mem[base + IDX_W'(1)] <= op_wdata[15:8];
      end
      if (op_size == 2'b10) begin
        mem[base + IDX_W'(2)] <= op_wdata[23:16];
        mem[base + IDX_W'(3)] <= op_wdata[31:24];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: three instances (LATENCY 1, 3 and 4) driven by
// directed sequences and randomized accesses checked against a byte-array model.
module tb_data_memory_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst3, rst4;

  data_memory_ctrl_if #(.ADDR_W(32)) b1 ();
  data_memory_ctrl_if #(.ADDR_W(32)) b3 ();
  data_memory_ctrl_if #(.ADDR_W(32)) b4 ();

  data_memory_ctrl #(.ADDR_W(32), .DEPTH_BYTES(1024), .LATENCY(1)) u1 (.clk_i(clk), .rst_i(rst1), .bus(b1));
  data_memory_ctrl #(.ADDR_W(32), .DEPTH_BYTES(1024), .LATENCY(3)) u3 (.clk_i(clk), .rst_i(rst3), .bus(b3));
  data_memory_ctrl #(.ADDR_W(32), .DEPTH_BYTES(1024), .LATENCY(4)) u4 (.clk_i(clk), .rst_i(rst4), .bus(b4));

  int nchk = 0;
  int nerr = 0;
  logic [7:0] mm [3][1024];
  logic [31:0] edge_addrs [7] = '{32'd1021, 32'd1022, 32'd1023, 32'd1024, 32'd1025,
                                 32'hFFFF_FFFF, 32'h8000_0000};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input logic req, input logic we, input logic [1:0] size,
                       input logic sign, input logic [31:0] addr, input logic [31:0] wd);
    case (s)
      0: begin b1.req_i = req; b1.we_i = we; b1.size_i = size; b1.sign_i = sign; b1.addr_i = addr; b1.data_i = wd; end
      1: begin b3.req_i = req; b3.we_i = we; b3.size_i = size; b3.sign_i = sign; b3.addr_i = addr; b3.data_i = wd; end
      default: begin b4.req_i = req; b4.we_i = we; b4.size_i = size; b4.sign_i = sign; b4.addr_i = addr; b4.data_i = wd; end
    endcase
  endtask

  function automatic logic rdy(input int s);
    case (s) 0: return b1.ready_o; 1: return b3.ready_o; default: return b4.ready_o; endcase
  endfunction
  function automatic logic rvl(input int s);
    case (s) 0: return b1.rvalid_o; 1: return b3.rvalid_o; default: return b4.rvalid_o; endcase
  endfunction
  function automatic logic eo(input int s);
    case (s) 0: return b1.err_o; 1: return b3.err_o; default: return b4.err_o; endcase
  endfunction
  function automatic logic [31:0] dout(input int s);
    case (s) 0: return b1.data_o; 1: return b3.data_o; default: return b4.data_o; endcase
  endfunction
  function automatic int lat_of(input int s);
    case (s) 0: return 1; 1: return 3; default: return 4; endcase
  endfunction

  // Reference: memory as a plain byte array, loads assembled little-endian.
  task automatic model(input int s, input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
    int nb;
    logic [31:0] v;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    er = (size == 2'd3) || ((addr % nb) != 0) || ((64'(addr) + 64'(nb)) > 64'd1024);
    rd = 32'd0;
    if (!er) begin
      if (we) begin
        for (int k = 0; k < nb; k++) mm[s][int'(addr) + k] = wd[8*k +: 8];
      end else begin
        v = 32'd0;
        for (int k = 0; k < nb; k++) v = v | (32'(mm[s][int'(addr) + k]) << (8*k));
        if (sign && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
        rd = v;
      end
    end
  endtask

  task automatic access(input int s, input logic we, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
    int n;
    n = 0;
    while (!rdy(s) && n < 20) begin @(posedge clk); #1; n++; end
    check("ready_before_req", {31'd0, rdy(s)}, 32'd1);
    drive(s, 1'b1, we, size, sign, addr, wd);
    @(posedge clk); #1;
    drive(s, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    n = 1;
    while (!rvl(s) && n < 20) begin @(posedge clk); #1; n++; end
    check("resp_latency", 32'(n), 32'(lat_of(s)));
    rd = dout(s);
    er = eo(s);
    @(posedge clk); #1;
    check("idle_rvalid_err", {30'd0, rvl(s), eo(s)}, 32'd0);
    check("idle_data", dout(s), 32'd0);
  endtask

  task automatic acc_chk(input string tag, input int s, input logic we, input logic [1:0] size,
                         input logic sign, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd, mrd;
    logic er, mer;
    access(s, we, size, sign, addr, wd, rd, er);
    model(s, we, size, sign, addr, wd, mrd, mer);
    check({tag, "_data"}, rd, exp_rd);
    check({tag, "_err"}, {31'd0, er}, {31'd0, exp_er});
  endtask

  task automatic rnd_acc(input int s, input logic we, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] rd, mrd;
    logic er, mer;
    access(s, we, size, sign, addr, wd, rd, er);
    model(s, we, size, sign, addr, wd, mrd, mer);
    check("rnd_data", rd, mrd);
    check("rnd_err", {31'd0, er}, {31'd0, mer});
  endtask

  initial begin
    logic [31:0] addr;
    logic [1:0] size;
    logic flag;
    logic [31:0] mrd;
    logic mer;

    for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    rst1 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // A request presented during reset must not be accepted.
    drive(0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hBAD0BAD0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    for (int s = 0; s < 3; s++) begin
      check("rst_ready", {31'd0, rdy(s)}, 32'd1);
      check("rst_rvalid", {31'd0, rvl(s)}, 32'd0);
      check("rst_data", dout(s), 32'd0);
      check("rst_err", {31'd0, eo(s)}, 32'd0);
    end
    rst1 = 1'b0; rst3 = 1'b0; rst4 = 1'b0;
    @(posedge clk); #1;

    // Little-endian word store, byte and word loads
    acc_chk("st_w10", 0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    acc_chk("ld_b10", 0, 0, 2'd0, 0, 32'h10, 32'h0, 32'h000000EF, 0);
    acc_chk("ld_b11", 0, 0, 2'd0, 0, 32'h11, 32'h0, 32'h000000BE, 0);
    acc_chk("ld_b12", 0, 0, 2'd0, 0, 32'h12, 32'h0, 32'h000000AD, 0);
    acc_chk("ld_b13", 0, 0, 2'd0, 0, 32'h13, 32'h0, 32'h000000DE, 0);
    acc_chk("ld_w10", 0, 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);

    // Sign and zero extension
    acc_chk("st_b21", 0, 1, 2'd0, 0, 32'h21, 32'h12345680, 32'h0, 0);
    acc_chk("ld_b21s", 0, 0, 2'd0, 1, 32'h21, 32'h0, 32'hFFFFFF80, 0);
    acc_chk("ld_b21u", 0, 0, 2'd0, 0, 32'h21, 32'h0, 32'h00000080, 0);
    acc_chk("st_h22", 0, 1, 2'd1, 0, 32'h22, 32'hABCD8001, 32'h0, 0);
    acc_chk("ld_h22s", 0, 0, 2'd1, 1, 32'h22, 32'h0, 32'hFFFF8001, 0);
    acc_chk("ld_h22u", 0, 0, 2'd1, 0, 32'h22, 32'h0, 32'h00008001, 0);
    acc_chk("ld_b21_again", 0, 0, 2'd0, 0, 32'h21, 32'h0, 32'h00000080, 0);

    // Error responses leave memory untouched
    acc_chk("st_w14", 0, 1, 2'd2, 0, 32'h14, 32'h00000000, 32'h0, 0);
    acc_chk("err_st_w13", 0, 1, 2'd2, 0, 32'h13, 32'h11223344, 32'h0, 1);
    acc_chk("err_ld_h05", 0, 0, 2'd1, 0, 32'h05, 32'h0, 32'h0, 1);
    acc_chk("err_ld_b400", 0, 0, 2'd0, 0, 32'h400, 32'h0, 32'h0, 1);
    acc_chk("err_st_b400", 0, 1, 2'd0, 0, 32'h400, 32'h77, 32'h0, 1);
    acc_chk("err_size3", 0, 0, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1);
    acc_chk("err_st_size3", 0, 1, 2'd3, 0, 32'h10, 32'h55555555, 32'h0, 1);
    acc_chk("keep_w10", 0, 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    acc_chk("keep_w14", 0, 0, 2'd2, 0, 32'h14, 32'h0, 32'h00000000, 0);

    // Top-of-memory boundary
    acc_chk("st_w3fc", 0, 1, 2'd2, 0, 32'd1020, 32'hA5A51234, 32'h0, 0);
    acc_chk("ld_b3ff", 0, 0, 2'd0, 1, 32'd1023, 32'h0, 32'hFFFFFFA5, 0);
    acc_chk("ld_h3fe", 0, 0, 2'd1, 0, 32'd1022, 32'h0, 32'h0000A5A5, 0);
    acc_chk("err_ld_w3fd", 0, 0, 2'd2, 0, 32'd1021, 32'h0, 32'h0, 1);
    acc_chk("err_st_w400", 0, 1, 2'd2, 0, 32'd1024, 32'h1, 32'h0, 1);
    acc_chk("err_ld_wtop", 0, 0, 2'd2, 0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1);

    // LATENCY=1 back-to-back store then load
    drive(0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h40, 32'h12345678);
    @(posedge clk); #1;
    check("b2b_st_rvalid", {31'd0, rvl(0)}, 32'd1);
    check("b2b_st_err", {31'd0, eo(0)}, 32'd0);
    check("b2b_st_data", dout(0), 32'd0);
    drive(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    check("b2b_ld_rvalid", {31'd0, rvl(0)}, 32'd1);
    check("b2b_ld_data", dout(0), 32'h12345678);
    model(0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h12345678, mrd, mer);
    @(posedge clk); #1;
    check("b2b_after_rvalid", {31'd0, rvl(0)}, 32'd0);

    // LATENCY=3 timing with req held through the wait
    drive(1, 1'b1, 1'b1, 2'd2, 1'b0, 32'h0, 32'hCAFE0001);
    @(posedge clk); #1;
    check("l3_e0_ready", {31'd0, rdy(1)}, 32'd0);
    check("l3_e0_rvalid", {31'd0, rvl(1)}, 32'd0);
    drive(1, 1'b1, 1'b1, 2'd2, 1'b0, 32'h4, 32'h0BADF00D);
    @(posedge clk); #1;
    check("l3_e1_ready", {31'd0, rdy(1)}, 32'd0);
    check("l3_e1_rvalid", {31'd0, rvl(1)}, 32'd0);
    @(posedge clk); #1;
    check("l3_e2_rvalid", {31'd0, rvl(1)}, 32'd1);
    check("l3_e2_ready", {31'd0, rdy(1)}, 32'd1);
    check("l3_e2_err", {31'd0, eo(1)}, 32'd0);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    check("l3_e3_ready", {31'd0, rdy(1)}, 32'd0);
    check("l3_e3_rvalid", {31'd0, rvl(1)}, 32'd0);
    @(posedge clk); #1;
    check("l3_e4_rvalid", {31'd0, rvl(1)}, 32'd0);
    @(posedge clk); #1;
    check("l3_e5_rvalid", {31'd0, rvl(1)}, 32'd1);
    @(posedge clk); #1;
    check("l3_e6_rvalid", {31'd0, rvl(1)}, 32'd0);
    model(1, 1'b1, 2'd2, 1'b0, 32'h0, 32'hCAFE0001, mrd, mer);
    model(1, 1'b1, 2'd2, 1'b0, 32'h4, 32'h0BADF00D, mrd, mer);
    acc_chk("l3_ld0", 1, 0, 2'd2, 0, 32'h0, 32'h0, 32'hCAFE0001, 0);
    acc_chk("l3_ld4", 1, 0, 2'd2, 0, 32'h4, 32'h0, 32'h0BADF00D, 0);

    // LATENCY=4 reset while a store is outstanding
    acc_chk("l4_st_old", 2, 1, 2'd2, 0, 32'h20, 32'h01020304, 32'h0, 0);
    drive(2, 1'b1, 1'b1, 2'd2, 1'b0, 32'h20, 32'hFFFF0000);
    @(posedge clk); #1;
    drive(2, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    check("l4_rst_ready", {31'd0, rdy(2)}, 32'd1);
    check("l4_rst_rvalid", {31'd0, rvl(2)}, 32'd0);
    flag = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rvl(2)) flag = 1'b1;
    end
    check("l4_no_resp", {31'd0, flag}, 32'd0);
    acc_chk("l4_ld_old", 2, 0, 2'd2, 0, 32'h20, 32'h0, 32'h01020304, 0);

    // Randomized accesses against the model
    for (int s = 0; s < 3; s++) begin
      for (int a = 0; a < 32; a++) rnd_acc(s, 1'b1, 2'd2, 1'b0, 32'(4 * a), $urandom);
      rnd_acc(s, 1'b1, 2'd2, 1'b0, 32'd1020, $urandom);
      for (int i = 0; i < 50; i++) begin
        size = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 9) < 8) addr = 32'($urandom_range(0, 127));
        else addr = edge_addrs[$urandom_range(0, 6)];
        rnd_acc(s, 1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr, $urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
